// File: rtl/gamepad_pkg.sv
// gamepad_pkg: constants shared by the dual-pad scan scheduler.
//   - button bit positions in the 12-bit button word
//   - pad pin positions in the 6-bit pin bus
//   - scan FSM state encoding
//   - phase numbers at which pins are sampled or six-button detection happens
// Optional feature macro: GAMEPAD_SIX_BUTTON_DETECT_EN (uses SIX_BTN_MASK).
`timescale 1ns/1ps
package gamepad_pkg;

    localparam int BTN_W      = 12;
    localparam int PIN_W      = 6;
    localparam int PAD_PHASES = 8;

    // Button word: bit11..0 = Mode,Start,Z,Y,X,C,B,A,Right,Left,Down,Up
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_X     = 7;
    localparam int BTN_Y     = 8;
    localparam int BTN_Z     = 9;
    localparam int BTN_START = 10;
    localparam int BTN_MODE  = 11;

    // Pin bus: bit0..5 = pin1,2,3,4,6,9 (all active-low)
    localparam int PIN1 = 0;
    localparam int PIN2 = 1;
    localparam int PIN3 = 2;
    localparam int PIN4 = 3;
    localparam int PIN6 = 4;
    localparam int PIN9 = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN0  = 3'd1,
        ST_GUARD  = 3'd2,
        ST_SCAN1  = 3'd3,
        ST_COMMIT = 3'd4
    } scan_state_t;

    localparam logic [2:0] PH_A_START  = 3'd1;
    localparam logic [2:0] PH_DPAD     = 3'd2;
    localparam logic [2:0] PH_B_C      = 3'd4;
    localparam logic [2:0] PH_DETECT   = 3'd5;
    localparam logic [2:0] PH_XYZ_MODE = 3'd6;

    // Buttons only reported by a six-button pad: Mode,Z,Y,X
    localparam logic [BTN_W-1:0] SIX_BTN_MASK =
        (12'd1 << BTN_MODE) | (12'd1 << BTN_Z) | (12'd1 << BTN_Y) | (12'd1 << BTN_X);

    // Select is low in odd phases, high in even phases
    function automatic logic select_level(input logic [2:0] phase);
        return ~phase[0];
    endfunction

endpackage

// File: rtl/gamepad_phase_decode.sv
// gamepad_phase_decode: combinational pin-to-button mapper for one scan phase.
// Ports:
//   phase      in  3   current phase index of the active pad poll
//   pins       in  6   active pad pins (active-low)
//   shadow_in  in  12  current shadow word of the active pad
//   shadow_out out 12  shadow word with this phase's buttons replaced
// Phases without a mapping pass the shadow word through unchanged.
`timescale 1ns/1ps
module gamepad_phase_decode
    import gamepad_pkg::*;
(
    input  logic [2:0]       phase,
    input  logic [PIN_W-1:0] pins,
    input  logic [BTN_W-1:0] shadow_in,
    output logic [BTN_W-1:0] shadow_out
);

    always_comb begin
        shadow_out = shadow_in;
        case (phase)
            PH_A_START: begin
                shadow_out[BTN_A]     = ~pins[PIN6];
                shadow_out[BTN_START] = ~pins[PIN9];
            end
            PH_DPAD: begin
                shadow_out[BTN_UP]    = ~pins[PIN1];
                shadow_out[BTN_DOWN]  = ~pins[PIN2];
                shadow_out[BTN_LEFT]  = ~pins[PIN3];
                shadow_out[BTN_RIGHT] = ~pins[PIN4];
            end
            PH_B_C: begin
                shadow_out[BTN_B] = ~pins[PIN6];
                shadow_out[BTN_C] = ~pins[PIN9];
            end
            PH_XYZ_MODE: begin
                shadow_out[BTN_X]    = ~pins[PIN3];
                shadow_out[BTN_Y]    = ~pins[PIN2];
                shadow_out[BTN_Z]    = ~pins[PIN1];
                shadow_out[BTN_MODE] = ~pins[PIN4];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/gamepad_scan_scheduler.sv
// gamepad_scan_scheduler: frame-synchronous scan of two Genesis-style pads.
// A v_sync falling edge polls pad 0 (8 phases), waits one guard phase, polls
// pad 1 (8 phases), then publishes both button words in a single commit cycle.
// Ports:
//   Clock50              in   system clock
//   Reset                in   synchronous, active-high
//   v_sync               in   async vsync; falling edge requests a scan
//   Enable               in   gates new requests in IDLE only
//   Pad0_Pins/Pad1_Pins  in   6-bit active-low pad pins
//   Select0/Select1      out  pad Select lines (registered)
//   Buttons0/Buttons1    out  12-bit active-high button words
//   Pressed0/Pressed1    out  rising-edge events, valid with FrameValid
//   FrameValid           out  one-cycle commit strobe
//   Busy                 out  high outside IDLE
//   Overrun              out  one-cycle pulse for a request seen while Busy
//   SixBtn0/SixBtn1      out  six-button pad detected (GAMEPAD_SIX_BUTTON_DETECT_EN only)
// Optional feature macro: GAMEPAD_SIX_BUTTON_DETECT_EN.
`timescale 1ns/1ps
module gamepad_scan_scheduler
    import gamepad_pkg::*;
#(
    parameter int PHASE_CYCLES = 1000,
    parameter int NUM_PHASES   = PAD_PHASES
) (
    input  logic             Clock50,
    input  logic             Reset,
    input  logic             v_sync,
    input  logic             Enable,
    input  logic [PIN_W-1:0] Pad0_Pins,
    input  logic [PIN_W-1:0] Pad1_Pins,
    output logic             Select0,
    output logic             Select1,
    output logic [BTN_W-1:0] Buttons0,
    output logic [BTN_W-1:0] Buttons1,
    output logic [BTN_W-1:0] Pressed0,
    output logic [BTN_W-1:0] Pressed1,
    output logic             FrameValid,
    output logic             Busy,
    output logic             Overrun
`ifdef GAMEPAD_SIX_BUTTON_DETECT_EN
    ,
    output logic             SixBtn0,
    output logic             SixBtn1
`endif
);

    localparam int              CW       = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(PHASE_CYCLES - 1);
    localparam logic [2:0]      PH_LAST  = 3'(NUM_PHASES - 1);

    // ---------------- v_sync synchroniser and falling-edge detect
    logic vs_meta, vs_sync, vs_prev;
    logic req;

    always_ff @(posedge Clock50) begin
        if (Reset) begin
            vs_meta <= 1'b0;
            vs_sync <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            vs_meta <= v_sync;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
        end
    end

    // Reset clears the chain to 0, so a high v_sync refilling it never looks like a fall
    assign req = vs_prev & ~vs_sync;

    // ---------------- scan FSM
    scan_state_t   state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    ph, ph_nx;
    logic          phase_end;

    assign phase_end = (cnt == CNT_LAST);
    assign Busy      = (state != ST_IDLE);

    always_ff @(posedge Clock50) begin
        if (Reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            ph    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ph    <= ph_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ph_nx    = ph;
        case (state)
            ST_IDLE: begin
                if (req && Enable) begin
                    state_nx = ST_SCAN0;
                    cnt_nx   = '0;
                    ph_nx    = '0;
                end
            end
            ST_SCAN0, ST_SCAN1: begin
                if (phase_end) begin
                    cnt_nx = '0;
                    ph_nx  = ph + 3'd1;
                    if (ph == PH_LAST) begin
                        state_nx = (state == ST_SCAN0) ? ST_GUARD : ST_COMMIT;
                        ph_nx    = '0;
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_GUARD: begin
                if (phase_end) begin
                    state_nx = ST_SCAN1;
                    cnt_nx   = '0;
                    ph_nx    = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_COMMIT: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
                ph_nx    = '0;
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
                ph_nx    = '0;
            end
        endcase
    end

    // ---------------- Select lines
    // Registered from next-state values so each Select level lines up
    // exactly with the phase it belongs to.
    always_ff @(posedge Clock50) begin
        if (Reset) begin
            Select0 <= 1'b1;
            Select1 <= 1'b1;
        end else begin
            Select0 <= (state_nx == ST_SCAN0) ? select_level(ph_nx) : 1'b1;
            Select1 <= (state_nx == ST_SCAN1) ? select_level(ph_nx) : 1'b1;
        end
    end

    // ---------------- shared decode, muxed to the active pad
    logic [1:0][BTN_W-1:0] shadow;
    logic [BTN_W-1:0]      dec_out;
    logic [PIN_W-1:0]      pins_act;
    logic                  pad_sel;
    logic                  sample_en;

    assign pad_sel   = (state == ST_SCAN1);
    assign pins_act  = pad_sel ? Pad1_Pins : Pad0_Pins;
    assign sample_en = ((state == ST_SCAN0) || (state == ST_SCAN1)) && phase_end;

    gamepad_phase_decode u_decode (
        .phase      (ph),
        .pins       (pins_act),
        .shadow_in  (shadow[pad_sel]),
        .shadow_out (dec_out)
    );

    always_ff @(posedge Clock50) begin
        if (Reset) begin
            shadow <= '0;
        end else if (sample_en) begin
            shadow[pad_sel] <= dec_out;
        end
    end

    // ---------------- commit word (optionally masked by six-button detect)
    logic [1:0][BTN_W-1:0] commit_word;

`ifdef GAMEPAD_SIX_BUTTON_DETECT_EN
    logic [1:0] det;
    logic [1:0] six_q;

    // A six-button pad pulls pins 1..4 low together in phase 5
    always_ff @(posedge Clock50) begin
        if (Reset) begin
            det <= '0;
        end else if (sample_en && (ph == PH_DETECT)) begin
            det[pad_sel] <= (pins_act[PIN4:PIN1] == 4'b0000);
        end
    end

    always_comb begin
        commit_word = shadow;
        for (int p = 0; p < 2; p++) begin
            if (!det[p]) commit_word[p] = shadow[p] & ~SIX_BTN_MASK;
        end
    end

    always_ff @(posedge Clock50) begin
        if (Reset) begin
            six_q <= '0;
        end else if (state == ST_COMMIT) begin
            six_q <= det;
        end
    end

    assign SixBtn0 = six_q[0];
    assign SixBtn1 = six_q[1];
`else
    assign commit_word = shadow;
`endif

    // ---------------- publish
    logic [1:0][BTN_W-1:0] buttons_q, pressed_q;

    always_ff @(posedge Clock50) begin
        if (Reset) begin
            buttons_q  <= '0;
            pressed_q  <= '0;
            FrameValid <= 1'b0;
            Overrun    <= 1'b0;
        end else begin
            pressed_q  <= '0;
            FrameValid <= 1'b0;
            Overrun    <= req && Busy;
            if (state == ST_COMMIT) begin
                buttons_q[0] <= commit_word[0];
                buttons_q[1] <= commit_word[1];
                pressed_q[0] <= commit_word[0] & ~buttons_q[0];
                pressed_q[1] <= commit_word[1] & ~buttons_q[1];
                FrameValid   <= 1'b1;
            end
        end
    end

    assign Buttons0 = buttons_q[0];
    assign Buttons1 = buttons_q[1];
    assign Pressed0 = pressed_q[0];
    assign Pressed1 = pressed_q[1];

endmodule
